// File: rtl/sweep_pkg.sv
// Shared state encoding and port-direction constants for the VNA sweep controller.
package sweep_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TUNE    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } sweep_state_e;

  localparam logic PORT_FWD = 1'b0;
  localparam logic PORT_REV = 1'b1;

endpackage

// File: rtl/sweep_down_counter.sv
// Loadable down counter with a registered zero flag; saturates at zero.
module sweep_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_d, count_q;
  logic         zero_d, zero_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/sparam_sweep_ctrl.sv
// 2-port VNA sweep sequencer: per point tunes the LO, then settles and captures
// a fixed beat block for the forward and then the reverse drive port.
module sparam_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LO_TIMEOUT = 4096
) (
  input  logic             s00_axis_aclk,
  input  logic             s00_axis_aresetn,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [CNT_W-1:0] cfg_num_points,
  input  logic [CNT_W-1:0] cfg_settle_cycles,
  input  logic [CNT_W-1:0] cfg_capture_len,
  output logic             lo_req,
  output logic [CNT_W-1:0] lo_freq_idx,
  input  logic             lo_ack,
  output logic             port_sel,
  input  logic             beat,
  output logic             capture_en,
  output logic             capture_last,
  output logic             busy,
  output logic             done,
  output logic             lo_err
);

  localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(LO_TIMEOUT - 1);

  // Counters load N-1 so the zero flag marks the final cycle/beat; 0 acts as 1.
  function automatic logic [CNT_W-1:0] minus_one_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  sweep_state_e     state_d, state_q;
  logic [CNT_W-1:0] last_idx_d, last_idx_q;
  logic [CNT_W-1:0] settle_ld_d, settle_ld_q;
  logic [CNT_W-1:0] cap_ld_d, cap_ld_q;
  logic [CNT_W-1:0] freq_idx_d, freq_idx_q;
  logic             port_sel_d, port_sel_q;
  logic             lo_err_d, lo_err_q;
  logic             lo_req_d, lo_req_q;
  logic             capture_en_d, capture_en_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;

  logic tmo_load, tmo_dec, tmo_zero;
  logic stl_load, stl_dec, stl_zero;
  logic cap_load, cap_dec, cap_zero;

  sweep_down_counter #(.W(CNT_W)) u_tmo_cnt (
    .clk      (s00_axis_aclk),
    .rst_n    (s00_axis_aresetn),
    .load     (tmo_load),
    .load_val (TMO_LD),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );

  sweep_down_counter #(.W(CNT_W)) u_settle_cnt (
    .clk      (s00_axis_aclk),
    .rst_n    (s00_axis_aresetn),
    .load     (stl_load),
    .load_val (settle_ld_q),
    .dec      (stl_dec),
    .zero     (stl_zero)
  );

  sweep_down_counter #(.W(CNT_W)) u_cap_cnt (
    .clk      (s00_axis_aclk),
    .rst_n    (s00_axis_aresetn),
    .load     (cap_load),
    .load_val (cap_ld_q),
    .dec      (cap_dec),
    .zero     (cap_zero)
  );

  always_comb begin
    state_d     = state_q;
    last_idx_d  = last_idx_q;
    settle_ld_d = settle_ld_q;
    cap_ld_d    = cap_ld_q;
    freq_idx_d  = freq_idx_q;
    port_sel_d  = port_sel_q;
    lo_err_d    = lo_err_q;
    tmo_load    = 1'b0;
    tmo_dec     = 1'b0;
    stl_load    = 1'b0;
    stl_dec     = 1'b0;
    cap_load    = 1'b0;
    cap_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          last_idx_d  = minus_one_sat(cfg_num_points);
          settle_ld_d = minus_one_sat(cfg_settle_cycles);
          cap_ld_d    = minus_one_sat(cfg_capture_len);
          lo_err_d    = 1'b0;
          freq_idx_d  = '0;
          port_sel_d  = PORT_FWD;
          tmo_load    = 1'b1;
          state_d     = TUNE;
        end
      end
      TUNE: begin
        // An ack on the final timeout cycle still counts as a lock.
        if (lo_ack) begin
          stl_load = 1'b1;
          state_d  = SETTLE;
        end else if (tmo_zero) begin
          lo_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (stl_zero) begin
          cap_load = 1'b1;
          state_d  = CAPTURE;
        end else begin
          stl_dec = 1'b1;
        end
      end
      CAPTURE: begin
        if (beat) begin
          if (cap_zero) begin
            state_d = NEXT;
          end else begin
            cap_dec = 1'b1;
          end
        end
      end
      NEXT: begin
        if (port_sel_q == PORT_FWD) begin
          port_sel_d = PORT_REV;
          stl_load   = 1'b1;
          state_d    = SETTLE;
        end else begin
          port_sel_d = PORT_FWD;
          if (freq_idx_q == last_idx_q) begin
            state_d = DONE;
          end else begin
            freq_idx_d = freq_idx_q + CNT_W'(1);
            tmo_load   = 1'b1;
            state_d    = TUNE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cfg_abort) begin
      state_d  = IDLE;
      lo_err_d = lo_err_q;
    end

    // Idle always presents a clean LO index and forward port.
    if (state_d == IDLE) begin
      freq_idx_d = '0;
      port_sel_d = PORT_FWD;
    end

    lo_req_d     = (state_d == TUNE);
    capture_en_d = (state_d == CAPTURE);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q      <= IDLE;
      last_idx_q   <= '0;
      settle_ld_q  <= '0;
      cap_ld_q     <= '0;
      freq_idx_q   <= '0;
      port_sel_q   <= PORT_FWD;
      lo_err_q     <= 1'b0;
      lo_req_q     <= 1'b0;
      capture_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_idx_q   <= last_idx_d;
      settle_ld_q  <= settle_ld_d;
      cap_ld_q     <= cap_ld_d;
      freq_idx_q   <= freq_idx_d;
      port_sel_q   <= port_sel_d;
      lo_err_q     <= lo_err_d;
      lo_req_q     <= lo_req_d;
      capture_en_q <= capture_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign lo_req       = lo_req_q;
  assign lo_freq_idx  = freq_idx_q;
  assign port_sel     = port_sel_q;
  assign capture_en   = capture_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign lo_err       = lo_err_q;
  assign capture_last = capture_en_q & beat & cap_zero;

endmodule

// File: tb/tb_sparam_sweep_ctrl.sv
// Self-checking bench for sparam_sweep_ctrl: directed steps plus randomized sweeps
// checked against an event-level model of the expected sweep.
module tb_sparam_sweep_ctrl;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LO_TMO = 16;

  logic             clk = 1'b0;
  logic             clk_run = 1'b1;
  logic             rst_n;
  logic             cfg_start, cfg_abort;
  logic [CNT_W-1:0] cfg_num_points, cfg_settle_cycles, cfg_capture_len;
  logic             lo_req;
  logic [CNT_W-1:0] lo_freq_idx;
  logic             lo_ack;
  logic             port_sel;
  logic             beat;
  logic             capture_en, capture_last, busy, done, lo_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int idx;
    int port;
    int beats;
    int lasts;
    int last_ok;
  } blk_t;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  sparam_sweep_ctrl #(.CNT_W(CNT_W), .LO_TIMEOUT(LO_TMO)) dut (
    .s00_axis_aclk     (clk),
    .s00_axis_aresetn  (rst_n),
    .cfg_start         (cfg_start),
    .cfg_abort         (cfg_abort),
    .cfg_num_points    (cfg_num_points),
    .cfg_settle_cycles (cfg_settle_cycles),
    .cfg_capture_len   (cfg_capture_len),
    .lo_req            (lo_req),
    .lo_freq_idx       (lo_freq_idx),
    .lo_ack            (lo_ack),
    .port_sel          (port_sel),
    .beat              (beat),
    .capture_en        (capture_en),
    .capture_last      (capture_last),
    .busy              (busy),
    .done              (done),
    .lo_err            (lo_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // All registered outputs at their idle/reset values.
  task automatic chk_idle(input string tag, input logic exp_err);
    chk({tag, ":lo_req"},     32'(lo_req), 0);
    chk({tag, ":freq_idx"},   32'(lo_freq_idx), 0);
    chk({tag, ":port_sel"},   32'(port_sel), 0);
    chk({tag, ":capture_en"}, 32'(capture_en), 0);
    chk({tag, ":busy"},       32'(busy), 0);
    chk({tag, ":done"},       32'(done), 0);
    chk({tag, ":lo_err"},     32'(lo_err), 32'(exp_err));
  endtask

  // Runs one sweep with the given config, then checks the observed event trace
  // against what the sweep rules predict. beat_mode: 0 tied high, 1 toggling, 2 random.
  task automatic run_sweep(input int num, input int settle, input int len,
                           input int ack_max, input int beat_mode, input string tag);
    int   n_eff, s_cyc, l_eff;
    int   cyc, ack_wait, ack_target, lat, gap, beats_run, lasts_run;
    int   done_cnt, stray_last, cur_idx, cur_port;
    bit   meas, gap_on, prev_cen, prev_lreq, prev_last, beat_tog;
    int   tunes[$];
    int   lats[$];
    int   gaps[$];
    blk_t got[$];

    n_eff = (num == 0) ? 1 : num;
    s_cyc = (settle == 0) ? 1 : settle;
    l_eff = (len == 0) ? 1 : len;

    cfg_num_points    = 16'(num);
    cfg_settle_cycles = 16'(settle);
    cfg_capture_len   = 16'(len);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk({tag, ":start_lo_req"}, 32'(lo_req), 1);
    chk({tag, ":start_busy"},   32'(busy), 1);
    cfg_num_points    = 16'($urandom);
    cfg_settle_cycles = 16'($urandom);
    cfg_capture_len   = 16'($urandom);

    cyc = 0; ack_wait = 0; ack_target = int'($urandom_range(ack_max, 0));
    lat = 0; gap = 0; beats_run = 0; lasts_run = 0; done_cnt = 0; stray_last = 0;
    cur_idx = 0; cur_port = 0;
    meas = 0; gap_on = 0; prev_cen = 0; prev_lreq = 0; prev_last = 0; beat_tog = 1;

    while (busy && cyc < 4000) begin
      cyc++;
      lo_ack = 1'b0;
      if (lo_req) begin
        if (ack_wait >= ack_target) begin
          lo_ack = 1'b1;
          ack_wait = 0;
          ack_target = int'($urandom_range(ack_max, 0));
        end else begin
          ack_wait++;
        end
      end else begin
        lo_ack = ($urandom_range(7, 0) == 0);
      end
      case (beat_mode)
        0:       beat = 1'b1;
        1:       begin beat = beat_tog; beat_tog = ~beat_tog; end
        default: beat = 1'($urandom_range(1, 0));
      endcase
      cfg_start = ($urandom_range(15, 0) == 0);
      #1;
      if (meas) begin
        lat++;
        if (capture_en) begin lats.push_back(lat); meas = 0; end
      end
      if (lo_req && !prev_lreq) tunes.push_back(32'(lo_freq_idx));
      if (lo_req && lo_ack) begin meas = 1; lat = 0; end
      if (!capture_en && prev_cen) begin
        got.push_back('{cur_idx, cur_port, beats_run, lasts_run, int'(prev_last)});
        beats_run = 0; lasts_run = 0;
        if (cur_port == 0) begin gap_on = 1; gap = 0; end
      end
      if (gap_on && !capture_en) gap++;
      if (gap_on && capture_en && !prev_cen) begin gaps.push_back(gap); gap_on = 0; end
      if (capture_en) begin
        cur_idx = 32'(lo_freq_idx);
        cur_port = 32'(port_sel);
        if (beat) beats_run++;
        if (capture_last) begin
          lasts_run++;
          if (!beat) stray_last++;
        end
      end else if (capture_last) begin
        stray_last++;
      end
      if (done) done_cnt++;
      prev_cen = capture_en; prev_lreq = lo_req; prev_last = capture_last;
      @(posedge clk);
      #1;
    end
    lo_ack = 1'b0; beat = 1'b0; cfg_start = 1'b0;

    chk({tag, ":terminated"}, 32'(cyc < 4000), 1);
    chk({tag, ":done_pulses"}, done_cnt, 1);
    chk({tag, ":stray_last"}, stray_last, 0);
    chk({tag, ":tunes"}, tunes.size(), n_eff);
    foreach (tunes[i]) chk($sformatf("%s:tune_idx%0d", tag, i), tunes[i], i);
    chk({tag, ":acks"}, lats.size(), n_eff);
    foreach (lats[i]) chk($sformatf("%s:ack_lat%0d", tag, i), lats[i], s_cyc + 1);
    chk({tag, ":gaps"}, gaps.size(), n_eff);
    foreach (gaps[i]) chk($sformatf("%s:port_gap%0d", tag, i), gaps[i], s_cyc + 1);
    chk({tag, ":blocks"}, got.size(), 2 * n_eff);
    foreach (got[k]) begin
      chk($sformatf("%s:blk%0d_idx", tag, k),   got[k].idx, k / 2);
      chk($sformatf("%s:blk%0d_port", tag, k),  got[k].port, k % 2);
      chk($sformatf("%s:blk%0d_beats", tag, k), got[k].beats, l_eff);
      chk($sformatf("%s:blk%0d_lasts", tag, k), got[k].lasts, 1);
      chk($sformatf("%s:blk%0d_lastend", tag, k), got[k].last_ok, 1);
    end
    chk_idle({tag, ":end"}, 1'b0);
  endtask

  initial begin
    int n, cyc;

    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_abort = 1'b0; lo_ack = 1'b0; beat = 1'b0;
    cfg_num_points = '0; cfg_settle_cycles = '0; cfg_capture_len = '0;
    step(); step(); step();
    chk_idle("reset", 1'b0);
    chk("reset:capture_last", 32'(capture_last), 0);
    rst_n = 1'b1;
    step();
    chk_idle("post_reset", 1'b0);

    // Beats and acks while idle do nothing.
    beat = 1'b1; lo_ack = 1'b1;
    step(); step();
    beat = 1'b0; lo_ack = 1'b0;
    chk_idle("idle_ignore", 1'b0);

    run_sweep(2, 3, 4, 0, 0, "basic");
    run_sweep(1, 2, 3, 2, 1, "toggle");
    run_sweep(0, 0, 0, 1, 0, "zero_cfg");

    // LO never acks: timeout after exactly LO_TMO cycles of request.
    cfg_num_points = 16'd2; cfg_settle_cycles = 16'd1; cfg_capture_len = 16'd1;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    n = 0; cyc = 0;
    while (lo_req && cyc < 200) begin
      if (done) n = 1000;
      n++; cyc++;
      step();
    end
    chk("tmo:req_cycles", n, LO_TMO);
    chk_idle("tmo:after", 1'b1);
    step();
    chk("tmo:no_done", 32'(done), 0);

    // Abort and start together: abort wins and lo_err is kept.
    cfg_start = 1'b1; cfg_abort = 1'b1;
    step();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    chk_idle("abort_start", 1'b1);

    // A fresh start clears the sticky error.
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("restart:lo_err", 32'(lo_err), 0);
    chk("restart:busy", 32'(busy), 1);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    chk_idle("restart_abort", 1'b0);

    // Abort in the middle of the reverse capture of point 1.
    cfg_num_points = 16'd2; cfg_settle_cycles = 16'd2; cfg_capture_len = 16'd6;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    cyc = 0;
    while (!(capture_en && port_sel && lo_freq_idx == 16'd1) && cyc < 500) begin
      lo_ack = lo_req;
      beat = 1'b1;
      cyc++;
      step();
    end
    lo_ack = 1'b0; beat = 1'b0;
    chk("abort:reached", 32'(cyc < 500), 1);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    chk_idle("abort_mid", 1'b0);

    // Async reset mid-SETTLE with the clock held.
    cfg_num_points = 16'd1; cfg_settle_cycles = 16'd20; cfg_capture_len = 16'd1;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    lo_ack = 1'b1;
    step();
    lo_ack = 1'b0;
    step(); step();
    chk("arst:in_settle_busy", 32'(busy), 1);
    chk("arst:in_settle_cen", 32'(capture_en), 0);
    chk("arst:in_settle_req", 32'(lo_req), 0);
    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle("arst", 1'b0);
    #5;
    rst_n = 1'b1;
    clk_run = 1'b1;
    step(); step();
    chk_idle("arst_release", 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_sweep(int'($urandom_range(3, 0)), int'($urandom_range(4, 0)),
                int'($urandom_range(5, 0)), 4, 2, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
